// File: rtl/alu_rr_sched.sv
// Round-robin scheduler that multiplexes N_REQ requesters onto one external combinational ALU.
// A grant registers the operands, EXEC captures the ALU result, RESP holds it until it is taken.
module alu_rr_sched #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [3*N_REQ-1:0] req_a,
  input  logic [3*N_REQ-1:0] req_b,
  input  logic [2*N_REQ-1:0] req_op,
  output logic [N_REQ-1:0]   req_ready,
  output logic [2:0]         alu_a,
  output logic [2:0]         alu_b,
  output logic [1:0]         alu_op,
  input  logic [15:0]        alu_out,
  input  logic               alu_ovf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_data,
  output logic               rsp_ovf,
  output logic               busy,
  output logic [15:0]        op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand;
  logic [2:0]       sel_a;
  logic [2:0]       sel_b;
  logic [1:0]       sel_op;
  logic             accept;

  // Scan from the farthest candidate to the nearest so the first valid after ptr wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    cand     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + IDW'(k);
      if (req_valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[3*i +: 3];
        sel_b  = req_b[3*i +: 3];
        sel_op = req_op[2*i +: 2];
      end
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IDW'(N_REQ - 1);
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            ptr    <= grant_id;
            rsp_id <= grant_id;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_ovf   <= alu_ovf;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Returning to IDLE here keeps a same-cycle request from being granted until next cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: a timing-level model predicts grants and responses,
// a separate monitor pops expected responses on every handshake.
module tb_alu_rr_sched;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_a;
  logic [3*N-1:0] req_b;
  logic [2*N-1:0] req_op;
  logic [2:0]     alu_a;
  logic [2:0]     alu_b;
  logic [1:0]     alu_op;
  logic [15:0]    alu_out;
  logic           alu_ovf;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [15:0]    rsp_data;
  logic           rsp_ovf;
  logic           busy;
  logic [15:0]    op_count;

  alu_rr_sched #(.N_REQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_out(alu_out), .alu_ovf(alu_ovf), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: add/sub/mul/negate on unsigned 3-bit operands, ovf on large sums.
  function automatic logic [16:0] alu_ref(input logic [2:0] a, input logic [2:0] b,
                                          input logic [1:0] op);
    int ia, ib, r;
    logic ovf;
    ia = int'(a);
    ib = int'(b);
    ovf = 1'b0;
    case (op)
      2'b00: begin r = ia + ib; ovf = (ia + ib >= 13); end
      2'b01: r = ia - ib;
      2'b10: r = ia * ib;
      default: r = -ia;
    endcase
    return {ovf, 16'(r)};
  endfunction

  assign {alu_ovf, alu_out} = alu_ref(alu_a, alu_b, alu_op);

  // Requester stimulus state
  logic       pv [N];
  logic [2:0] pa [N];
  logic [2:0] pb [N];
  logic [1:0] pop[N];

  always_comb begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = pv[i];
      req_a[3*i +: 3]   = pa[i];
      req_b[3*i +: 3]   = pb[i];
      req_op[2*i +: 2]  = pop[i];
    end
  end

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endfunction

  // Reference model: one operation at a time, response visible from acceptance+2 until taken.
  logic       m_busy;
  int         m_acc;
  int         m_ptr;
  int         m_count;
  logic [2:0] m_a, m_b;
  logic [1:0] m_op;
  logic [N-1:0] acc_mask;
  int acc_log[$];
  int acc_id_log[$];

  always @(negedge clk) begin : model
    logic [N-1:0] exp_ready;
    logic [16:0]  r;
    int g;
    if (rst) begin
      m_busy = 1'b0; m_ptr = N - 1; m_count = 0; m_acc = 0;
      m_a = '0; m_b = '0; m_op = '0;
      acc_mask = '0;
      sb.delete();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_fields", {rsp_id, rsp_data, rsp_ovf, alu_a, alu_b, alu_op}, 0);
    end else begin
      exp_ready = '0;
      g = -1;
      if (!m_busy)
        for (int k = 1; k <= N; k++)
          if (g < 0 && pv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_busy && cyc >= m_acc + 2);
      chk("op_count", op_count, m_count);
      chk("alu_regs", {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
      acc_mask = req_ready & req_valid;
      for (int i = 0; i < N; i++)
        if (acc_mask[i]) begin
          acc_log.push_back(cyc);
          acc_id_log.push_back(i);
        end
      if (m_busy && cyc >= m_acc + 2 && rsp_ready) begin
        m_busy  = 1'b0;
        m_count = (m_count + 1) & 16'hFFFF;
      end else if (g >= 0) begin
        r = alu_ref(pa[g], pb[g], pop[g]);
        sb.push_back('{id: g, data: r[15:0], ovf: r[16], acc: cyc});
        m_busy = 1'b1; m_acc = cyc; m_ptr = g;
        m_a = pa[g]; m_b = pb[g]; m_op = pop[g];
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  logic        prev_valid = 1'b0;
  logic        prev_hold = 1'b0;
  logic [1:0]  prev_id;
  logic [15:0] prev_data;
  logic        prev_ovf;
  logic [15:0] last_data;
  logic        last_ovf;
  int hs_ids[$];
  int hs_cycles[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (prev_hold)
        chk("rsp_stable", {rsp_valid, rsp_id, rsp_data, rsp_ovf}, {1'b1, prev_id, prev_data, prev_ovf});
      if (rsp_valid && !prev_valid && sb.size() > 0)
        chk("latency", cyc, sb[0].acc + 2);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: actual id=%0d data=%04h required no response cycle=%0d",
                   rsp_id, rsp_data, cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_ovf", rsp_ovf, e.ovf);
          $display("rsp id=%0d data=%04h ovf=%0b cycle=%0d", rsp_id, rsp_data, rsp_ovf, cyc);
          hs_ids.push_back(int'(rsp_id));
          hs_cycles.push_back(cyc);
          last_data = rsp_data;
          last_ovf  = rsp_ovf;
        end
      end
      prev_hold  = rsp_valid && !rsp_ready;
      prev_valid = rsp_valid;
      prev_id    = rsp_id;
      prev_data  = rsp_data;
      prev_ovf   = rsp_ovf;
    end
  end

  int mode = 0;  // 0 directed, 1 refill on accept, 2 random

  task automatic load(input int i);
    pv[i]  = 1'b1;
    pa[i]  = 3'($urandom_range(0, 7));
    pb[i]  = 3'($urandom_range(0, 7));
    pop[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic load_fixed(input int i, input logic [2:0] a, input logic [2:0] b,
                            input logic [1:0] op);
    pv[i] = 1'b1; pa[i] = a; pb[i] = b; pop[i] = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) begin
        pv[i] = 1'b0;
        if (mode == 1) load(i);
      end else if (mode == 2) begin
        if (!pv[i] && $urandom_range(0, 3) == 0) load(i);
        else if (pv[i] && $urandom_range(0, 15) == 0) pv[i] = 1'b0;
      end
    end
    if (mode == 2) rsp_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_hs(input string name);
    int n0, t;
    n0 = hs_ids.size();
    t = 0;
    while (hs_ids.size() == n0 && t < 30) begin step(); t++; end
    if (hs_ids.size() == n0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: actual no handshake within 30 cycles, required a handshake", name);
    end
  endtask

  task automatic wait_acc(input string name);
    int n0, t;
    n0 = acc_log.size();
    t = 0;
    while (acc_log.size() == n0 && t < 30) begin step(); t++; end
    if (acc_log.size() == n0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: actual no acceptance within 30 cycles, required an acceptance", name);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_busy && t < 30) begin step(); t++; end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    rst = 1'b1;
    #1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [2:0]  t_a [3] = '{3'd2, 3'd7, 3'd1};
  logic [2:0]  t_b [3] = '{3'd5, 3'd7, 3'd0};
  logic [1:0]  t_op[3] = '{2'b01, 2'b10, 2'b11};
  logic [15:0] t_d [3] = '{16'hFFFD, 16'h0031, 16'hFFFF};

  initial begin
    int base, hbase, hcyc, hs0, t;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; pop[i] = '0;
    end
    rsp_ready = 1'b1;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    step();
    step();

    // Single add on requester 0 right after reset release
    rst = 1'b0;
    load_fixed(0, 3'd5, 3'd3, 2'b00);
    wait_hs("add_hs");
    chk("add_data", last_data, 16'h0008);
    chk("add_ovf", last_ovf, 0);
    chk("add_id", hs_ids[$], 0);
    chk("add_count", op_count, 1);

    // Sub, mul, negate on requester 2
    for (int k = 0; k < 3; k++) begin
      load_fixed(2, t_a[k], t_b[k], t_op[k]);
      wait_hs("op2_hs");
      chk("op2_data", last_data, t_d[k]);
      chk("op2_ovf", last_ovf, 0);
      chk("op2_id", hs_ids[$], 2);
    end
    wait_idle();

    // Round-robin fairness with all requesters held valid
    do_reset();
    mode = 1;
    for (int i = 0; i < N; i++) load(i);
    base = acc_id_log.size();
    hbase = hs_ids.size();
    t = 0;
    while (hs_ids.size() < hbase + 6 && t < 40) begin step(); t++; end
    for (int k = 0; k < 6; k++) begin
      if (acc_id_log.size() > base + k) chk("rr_grant", acc_id_log[base + k], k % 4);
      else chk("rr_grant_count", acc_id_log.size(), base + 6);
      if (hs_ids.size() > hbase + k) chk("rr_rsp_id", hs_ids[hbase + k], k % 4);
      if (k > 0 && acc_log.size() > base + k)
        chk("rr_spacing", acc_log[base + k] - acc_log[base + k - 1], 3);
    end
    mode = 0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    wait_idle();

    // Backpressure with requester 1 waiting
    rsp_ready = 1'b0;
    load(0);
    t = 0;
    while (!rsp_valid && t < 10) begin step(); t++; end
    load(1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_rsp_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    wait_hs("bp_hs");
    hcyc = hs_cycles[$];
    wait_acc("bp_acc");
    chk("bp_next_grant_cycle", acc_log[$], hcyc + 1);
    chk("bp_next_grant_id", acc_id_log[$], 1);
    wait_hs("bp_hs2");
    wait_idle();

    // Reset during EXEC discards the operation
    load(2);
    wait_acc("exec_acc");
    hs0 = hs_ids.size();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_op_count", op_count, 0);
    step();
    step();
    rst = 1'b0;
    load(3);
    load(0);
    wait_acc("post_rst_acc");
    chk("post_rst_first_grant", acc_id_log[$], 0);
    chk("post_rst_no_rsp", hs_ids.size(), hs0);

    // Random traffic with random backpressure and dropped requests
    mode = 2;
    repeat (400) step();
    mode = 0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) step();
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual simulation still running at 100000ns, required completion");
    $fatal(1, "watchdog");
  end
endmodule
